// File: rtl/fir_pkg.sv
// Shared widths, FSM encoding and helpers for the fir_ctrl filter sequencer.
package fir_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 39;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_OUT  = 2'd3
  } fir_state_t;

  // Clamp the wide accumulator to the 16-bit output range.
  function automatic logic [DATA_W-1:0] sat16(input logic [ACC_W-1:0] v);
    return (v > ACC_W'(65535)) ? {DATA_W{1'b1}} : v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: one write port at wr_ptr, one read port at wr_ptr-offset.
// Every entry clears on reset.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wr_ptr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     offset,
  output logic [DATA_W-1:0] rdata
);

  logic [NTAPS-1:0][DATA_W-1:0] mem;
  logic [AW-1:0]                rd_addr;

  for (genvar i = 0; i < NTAPS; i++) begin : g_entry
    logic [DATA_W-1:0] q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                          q <= '0;
      else if (we && wr_ptr == AW'(i))  q <= wdata;
    end
    assign mem[i] = q;
  end

  // NTAPS is a power of two, so AW-bit subtraction is already modulo NTAPS.
  assign rd_addr = wr_ptr - offset;
  assign rdata   = mem[rd_addr];

endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencer: accepts a sample, walks NTAPS taps through an external MAC, presents the sum.
// Optional FIR_CTRL_SAT_EN adds a 16-bit saturated copy of the result on m_sat.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int NTAPS   = 8,
  parameter int MAC_LAT = 2,
  localparam int AW     = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [DATA_W-1:0] coef_wdata,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_data,
`ifdef FIR_CTRL_SAT_EN
  output logic [DATA_W-1:0] m_sat,
`endif
  output logic [DATA_W-1:0] mac_x,
  output logic [DATA_W-1:0] mac_b,
  output logic [ACC_W-1:0]  mac_sum_in,
  input  logic [ACC_W-1:0]  mac_sum_out,
  output logic              busy
);

  localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  fir_state_t                   state;
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                k;
  logic [LW-1:0]                lat_cnt;
  logic [ACC_W-1:0]             acc;
  logic [DATA_W-1:0]            smp;
  logic [NTAPS-1:0][DATA_W-1:0] coef;
  logic [DATA_W-1:0]            tap_x;
  logic                         tap_last;
  logic                         in_run;

  assign busy     = (state != ST_IDLE);
  assign s_ready  = (state == ST_IDLE);
  assign in_run   = (state == ST_RUN);
  assign tap_last = (lat_cnt == LW'(MAC_LAT - 1));

  fir_delay_line #(.NTAPS(NTAPS), .AW(AW)) u_dly (
    .clk    (clk),
    .rst    (rst),
    .we     (state == ST_LOAD),
    .wr_ptr (wr_ptr),
    .wdata  (smp),
    .offset (k),
    .rdata  (tap_x)
  );

  // Operands come straight from registered state so they stay put for the whole tap.
  assign mac_x      = in_run ? tap_x   : '0;
  assign mac_b      = in_run ? coef[k] : '0;
  assign mac_sum_in = in_run ? acc     : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef <= '0;
    end else if (coef_we && !busy) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      k       <= '0;
      lat_cnt <= '0;
      acc     <= '0;
      smp     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
`ifdef FIR_CTRL_SAT_EN
      m_sat   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            smp   <= s_data;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          acc     <= '0;
          k       <= '0;
          lat_cnt <= '0;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          if (tap_last) begin
            lat_cnt <= '0;
            acc     <= mac_sum_out;
            k       <= k + AW'(1);
            if (k == AW'(NTAPS - 1)) state <= ST_OUT;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        ST_OUT: begin
          // First OUT cycle publishes the result; afterwards it is held until taken.
          if (!m_valid) begin
            m_valid <= 1'b1;
            m_data  <= acc;
`ifdef FIR_CTRL_SAT_EN
            m_sat   <= sat16(acc);
`endif
          end else if (m_ready) begin
            m_valid <= 1'b0;
            wr_ptr  <= wr_ptr + AW'(1);
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl (NTAPS=4, MAC_LAT=2) with a behavioural MAC and FIR reference.
module tb_fir_ctrl;
  import fir_pkg::*;

  localparam int NTAPS   = 4;
  localparam int MAC_LAT = 2;
  localparam int AW      = $clog2(NTAPS);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [15:0]       coef_wdata = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [15:0]       s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [38:0]       m_data;
`ifdef FIR_CTRL_SAT_EN
  logic [15:0]       m_sat;
`endif
  logic [15:0]       mac_x, mac_b;
  logic [38:0]       mac_sum_in;
  logic [38:0]       mac_sum_out;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [15:0]       mcoef [NTAPS];
  longint unsigned   hist [$];

  fir_ctrl #(.NTAPS(NTAPS), .MAC_LAT(MAC_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
`ifdef FIR_CTRL_SAT_EN
    .m_sat       (m_sat),
`endif
    .mac_x       (mac_x),
    .mac_b       (mac_b),
    .mac_sum_in  (mac_sum_in),
    .mac_sum_out (mac_sum_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // External MAC: result of the operands seen at one edge is available from the next one on.
  logic [38:0] mac_p = '0;
  always @(posedge clk) mac_p <= mac_x * mac_b + mac_sum_in;
  assign mac_sum_out = mac_p;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: y = sum_k coef[k] * x[n-k], older samples zero since reset.
  function automatic logic [38:0] model_push(input logic [15:0] d);
    longint unsigned s = 0;
    hist.push_front(longint'(d));
    if (hist.size() > NTAPS) void'(hist.pop_back());
    for (int i = 0; i < hist.size(); i++) s += longint'(mcoef[i]) * hist[i];
    return s[38:0];
  endfunction

  task automatic model_clear;
    hist.delete();
    for (int i = 0; i < NTAPS; i++) mcoef[i] = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic write_coef(input int addr, input logic [15:0] val);
    coef_we    = 1'b1;
    coef_addr  = AW'(addr);
    coef_wdata = val;
    tick;
    coef_we    = 1'b0;
    mcoef[addr] = val;
  endtask

  task automatic run_sample(input logic [15:0] d, input logic [38:0] expv, input int hold);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    tick;
    s_valid = 1'b0;
    s_data  = 16'($urandom);
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept busy=%b s_ready=%b required busy=1 s_ready=0", busy, s_ready);
    end
    n = 0;
    // Coefficient writes while busy must be dropped; poke them continuously.
    while (m_valid !== 1'b1 && n < 40) begin
      coef_we    = 1'($urandom);
      coef_addr  = AW'($urandom);
      coef_wdata = 16'($urandom);
      tick;
      n++;
    end
    coef_we = 1'b0;
    checks++;
    if (n != NTAPS * MAC_LAT + 2) begin
      errors++;
      $display("FAIL latency got %0d cycles required %0d", n, NTAPS * MAC_LAT + 2);
    end
    checks++;
    if (m_data !== expv) begin
      errors++;
      $display("FAIL data sample=%0d got %0d required %0d", d, m_data, expv);
    end
    checks++;
    if (mac_x !== 16'd0 || mac_b !== 16'd0 || mac_sum_in !== 39'd0) begin
      errors++;
      $display("FAIL mac_idle got x=%0d b=%0d s=%0d required 0", mac_x, mac_b, mac_sum_in);
    end
`ifdef FIR_CTRL_SAT_EN
    checks++;
    if (m_sat !== ((expv > 39'd65535) ? 16'hFFFF : expv[15:0])) begin
      errors++;
      $display("FAIL m_sat got %0d for result %0d", m_sat, expv);
    end
`endif
    for (int i = 0; i < hold; i++) begin
      coef_we    = 1'b1;
      coef_addr  = AW'($urandom);
      coef_wdata = 16'($urandom);
      tick;
      checks++;
      if (m_valid !== 1'b1 || m_data !== expv || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc=%0d m_valid=%b m_data=%0d s_ready=%b required 1/%0d/0",
                 i, m_valid, m_data, s_ready, expv);
      end
    end
    coef_we = 1'b0;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release m_valid=%b s_ready=%b busy=%b required 0/1/0", m_valid, s_ready, busy);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 39'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s s_ready=%b m_valid=%b m_data=%0d busy=%b required 1/0/0/0",
               tag, s_ready, m_valid, m_data, busy);
    end
    checks++;
    if (mac_x !== 16'd0 || mac_b !== 16'd0 || mac_sum_in !== 39'd0) begin
      errors++;
      $display("FAIL %s_mac x=%0d b=%0d s=%0d required 0", tag, mac_x, mac_b, mac_sum_in);
    end
`ifdef FIR_CTRL_SAT_EN
    checks++;
    if (m_sat !== 16'd0) begin
      errors++;
      $display("FAIL %s_sat got %0d required 0", tag, m_sat);
    end
`endif
  endtask

  task automatic test_reset;
    do_reset();
    check_reset_vals("reset");
  endtask

  task automatic test_basic;
    logic [38:0] e [3] = '{39'd10, 39'd40, 39'd100};
    logic [15:0] x [3] = '{16'd10, 16'd20, 16'd30};
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'(i + 1));
    for (int i = 0; i < 3; i++) begin
      void'(model_push(x[i]));
      run_sample(x[i], e[i], 0);
    end
  endtask

  task automatic test_wrap;
    logic [38:0] e [5] = '{39'd5, 39'd6, 39'd7, 39'd8, 39'd0};
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'(i + 5));
    for (int i = 0; i < 5; i++) begin
      void'(model_push((i == 0) ? 16'd1 : 16'd0));
      run_sample((i == 0) ? 16'd1 : 16'd0, e[i], 1);
    end
  endtask

  task automatic test_hold;
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'(i + 1));
    void'(model_push(16'd9));
    run_sample(16'd9, 39'd9, 10);
    void'(model_push(16'd1));
    run_sample(16'd1, 39'd19, 2);
  endtask

  task automatic test_sat;
    logic [38:0] e [4] = '{39'd4294836225, 39'd8589672450, 39'd12884508675, 39'd17179344900};
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      void'(model_push(16'hFFFF));
      run_sample(16'hFFFF, e[i], 0);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'($urandom_range(1, 65535)));
    s_valid = 1'b1;
    s_data  = 16'd500;
    tick;
    s_valid = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_run");
    tick;
    rst = 1'b0;
    model_clear();
    tick;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_rst s_ready=%b required 1", s_ready);
    end
    write_coef(0, 16'd3);
    void'(model_push(16'd7));
    run_sample(16'd7, 39'd21, 0);
    // Reset while a result is waiting in OUT.
    write_coef(1, 16'd2);
    s_valid = 1'b1;
    s_data  = 16'd4;
    tick;
    s_valid = 1'b0;
    repeat (NTAPS * MAC_LAT + 3) tick;
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_wait m_valid=%b required 1", m_valid);
    end
    rst = 1'b1;
    #1;
    check_reset_vals("rst_out");
    tick;
    rst = 1'b0;
    model_clear();
    tick;
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    logic [38:0] e;
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'($urandom));
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 5))
        0:       d = 16'd0;
        1:       d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
      e = model_push(d);
      run_sample(d, e, int'($urandom_range(0, 3)));
      if (n == 15) write_coef(int'($urandom_range(0, NTAPS - 1)), 16'($urandom));
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_sat();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
